// File: rtl/dmem_responder.sv
// Single-port 64-bit data memory responder with fixed-latency request/response handshake.
// Sub-word loads and stores are supported; misaligned or out-of-range accesses return an error.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// WAIT  | request captured; latency counter running down to 0
// RESP  | response registered; rsp_valid=1 until rsp_ready
module dmem_responder #(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic        accept;
    logic        perform;

    logic        cap_wen;
    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic [1:0]  cap_size;
    logic        cap_signed;

    logic [63:0] mem [DEPTH];

    logic [IW-1:0] word_idx;
    logic [2:0]    lane_off;
    logic          out_of_range;
    logic          misaligned;
    logic          acc_err;
    logic [63:0]   rd_word;
    logic [63:0]   rd_shift;
    logic [63:0]   load_data;
    logic [63:0]   wr_shift;
    logic [7:0]    lane_mask;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        perform   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = LAT_M1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    perform   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Access decode works only from the captured fields, so the request bus may change freely after acceptance.
    always_comb begin
        word_idx     = cap_addr[3 +: IW];
        lane_off     = cap_addr[2:0];
        out_of_range = |cap_addr[63:3+IW];
        case (cap_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = cap_addr[0];
            2'd2:    misaligned = |cap_addr[1:0];
            default: misaligned = |cap_addr[2:0];
        endcase
        acc_err = misaligned | out_of_range;

        case (cap_size)
            2'd0:    lane_mask = 8'h01;
            2'd1:    lane_mask = 8'h03;
            2'd2:    lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
        lane_mask = lane_mask << lane_off;
        wr_shift  = cap_wdata << {lane_off, 3'b000};

        rd_word  = mem[word_idx];
        rd_shift = rd_word >> {lane_off, 3'b000};
        case (cap_size)
            2'd0:    load_data = cap_signed ? {{56{rd_shift[7]}},  rd_shift[7:0]}
                                            : {56'd0, rd_shift[7:0]};
            2'd1:    load_data = cap_signed ? {{48{rd_shift[15]}}, rd_shift[15:0]}
                                            : {48'd0, rd_shift[15:0]};
            2'd2:    load_data = cap_signed ? {{32{rd_shift[31]}}, rd_shift[31:0]}
                                            : {32'd0, rd_shift[31:0]};
            default: load_data = rd_shift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            cap_wen    <= 1'b0;
            cap_addr   <= 64'd0;
            cap_wdata  <= 64'd0;
            cap_size   <= 2'd0;
            cap_signed <= 1'b0;
            rsp_rdata  <= 64'd0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_wen    <= req_wen;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
                cap_size   <= req_size;
                cap_signed <= req_signed;
            end
            if (perform) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || cap_wen) ? 64'd0 : load_data;
            end
        end
    end

    // Memory has no reset; a write needs perform, which is held off while the state register is in reset.
    always_ff @(posedge clk) begin
        if (perform && cap_wen && !acc_err) begin
            for (int b = 0; b < 8; b++) begin
                if (lane_mask[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_shift[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: loads/stores, sign extension, errors, backpressure and reset abort.
module tb_dmem_responder;

    localparam int DEPTH = 8;
    localparam int LAT   = 2;
    localparam logic [63:0] PAT = 64'hA5A5_5A5A_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .req_signed (req_signed),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction; hold>0 keeps rsp_ready low for that many cycles in RESP.
    task automatic xfer(input string tag, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [1:0] size, input logic sgn,
                        input logic [63:0] exp_rd, input logic exp_err, input int hold);
        int n;
        logic [63:0] held_rd;
        logic        held_err;
        @(negedge clk);
        chk({tag, " ready"}, 64'(req_ready), 64'd1);
        rsp_ready  = (hold == 0);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_wen    = ~wen;
        req_addr   = 64'hFFFF_FFFF_FFFF_FFF8;
        req_wdata  = ~wdata;
        req_size   = ~size;
        req_signed = ~sgn;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rsp_valid && n < 20);
        chk({tag, " latency"}, 64'(n), 64'(LAT));
        chk({tag, " rdata"}, rsp_rdata, exp_rd);
        chk({tag, " err"}, 64'(rsp_err), 64'(exp_err));
        held_rd  = rsp_rdata;
        held_err = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold valid"}, 64'(rsp_valid), 64'd1);
            chk({tag, " hold ready"}, 64'(req_ready), 64'd0);
            chk({tag, " hold rdata"}, rsp_rdata, held_rd);
            chk({tag, " hold err"}, 64'(rsp_err), 64'(held_err));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " done valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, " done ready"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        rsp_ready  = 1'b1;
        #1;
        chk("reset ready", 64'(req_ready), 64'd1);
        chk("reset valid", 64'(rsp_valid), 64'd0);
        chk("reset rdata", rsp_rdata, 64'd0);
        chk("reset err", 64'(rsp_err), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            xfer("init", 1'b1, 64'(8*i), PAT | 64'(i), 2'd3, 1'b0, 64'd0, 1'b0, 0);

        xfer("st dbl 10", 1'b1, 64'h10, 64'h1122334455667788, 2'd3, 1'b0, 64'd0, 1'b0, 0);
        xfer("ld dbl 10", 1'b0, 64'h10, 64'd0, 2'd3, 1'b1, 64'h1122334455667788, 1'b0, 0);

        xfer("st byte 13", 1'b1, 64'h13, 64'hDEADBEEF00000080, 2'd0, 1'b0, 64'd0, 1'b0, 0);
        xfer("ld byte s", 1'b0, 64'h13, 64'd0, 2'd0, 1'b1, 64'hFFFFFFFFFFFFFF80, 1'b0, 0);
        xfer("ld byte u", 1'b0, 64'h13, 64'd0, 2'd0, 1'b0, 64'h0000000000000080, 1'b0, 0);
        xfer("ld dbl merged", 1'b0, 64'h10, 64'd0, 2'd3, 1'b0, 64'h1122334480667788, 1'b0, 0);

        xfer("st word 14", 1'b1, 64'h14, 64'h0123456789ABCDEF, 2'd2, 1'b0, 64'd0, 1'b0, 0);
        xfer("ld word s", 1'b0, 64'h14, 64'd0, 2'd2, 1'b1, 64'hFFFFFFFF89ABCDEF, 1'b0, 0);
        xfer("ld word u", 1'b0, 64'h14, 64'd0, 2'd2, 1'b0, 64'h0000000089ABCDEF, 1'b0, 0);
        xfer("ld half u16", 1'b0, 64'h16, 64'd0, 2'd1, 1'b0, 64'h00000000000089AB, 1'b0, 0);
        xfer("ld half s12", 1'b0, 64'h12, 64'd0, 2'd1, 1'b1, 64'hFFFFFFFFFFFF8066, 1'b0, 0);

        xfer("ld half misal", 1'b0, 64'h11, 64'd0, 2'd1, 1'b0, 64'd0, 1'b1, 0);
        xfer("st word oor", 1'b1, 64'(8*DEPTH), 64'h00000000CAFEF00D, 2'd2, 1'b0, 64'd0, 1'b1, 0);
        xfer("st dbl misal", 1'b1, 64'h04, 64'h1111111111111111, 2'd3, 1'b0, 64'd0, 1'b1, 0);
        xfer("ld oor", 1'b0, 64'h48, 64'd0, 2'd3, 1'b0, 64'd0, 1'b1, 0);
        for (int i = 0; i < DEPTH; i++)
            xfer("readback", 1'b0, 64'(8*i), 64'd0, 2'd3, 1'b0,
                 (i == 2) ? 64'h89ABCDEF80667788 : (PAT | 64'(i)), 1'b0, 0);

        xfer("hold ld 08", 1'b0, 64'h08, 64'd0, 2'd3, 1'b0, PAT | 64'd1, 1'b0, 5);

        xfer("pre-rst ld 20", 1'b0, 64'h20, 64'd0, 2'd3, 1'b0, PAT | 64'd4, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'h0000000000001234;
        req_size  = 2'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort in wait", 64'(req_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("abort ready", 64'(req_ready), 64'd1);
        chk("abort valid", 64'(rsp_valid), 64'd0);
        chk("abort rdata", rsp_rdata, 64'd0);
        chk("abort err", 64'(rsp_err), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        xfer("post-rst ld 20", 1'b0, 64'h20, 64'd0, 2'd3, 1'b0, PAT | 64'd4, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
